// File: rtl/video_mixer_pkg.sv
// video_mixer_pkg: shared types and helpers for the video mixer.
//   sync_t      - bundle of sync/blank flags travelling with a pixel
//   LAT_DIRECT  - input-to-output latency of the direct path, in clk_sys cycles
//   expand8()   - widen a cw-bit colour component to 8 bits by bit replication
//   dim()       - scanline attenuation c * (2^slw - lvl) / 2^slw, truncated
package video_mixer_pkg;

  localparam int unsigned LAT_DIRECT = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  // x holds the component right-aligned in its low cw bits.
  function automatic logic [7:0] expand8(input logic [7:0] x, input int unsigned cw);
    logic [7:0] y;
    y = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      y[7 - i] = x[cw - 1 - (i % cw)];
    end
    return y;
  endfunction

  // Product is wide enough for slw up to 8 so no intermediate bits are lost.
  function automatic logic [7:0] dim(input logic [7:0] c, input logic [7:0] lvl,
                                     input int unsigned slw);
    logic [16:0] p;
    p = 17'(c) * ((17'd1 << slw) - 17'(lvl));
    p = p >> slw;
    return p[7:0];
  endfunction

endpackage

// File: rtl/video_mixer_dim.sv
// video_mixer_dim: output register stage for one colour component.
//   clk, reset - clock and synchronous active-high reset
//   c          - 8-bit component from the path-select stage
//   lvl        - scanline level already gated by line parity (0 = no dimming)
//   de_next    - data enable the output will carry alongside this pixel
//   q          - registered, dimmed (and optionally blanked) component
import video_mixer_pkg::*;

module video_mixer_dim #(
  parameter int unsigned SLW         = 2,
  parameter bit          BLANK_BLACK = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     c,
  input  logic [SLW-1:0] lvl,
  input  logic           de_next,
  output logic [7:0]     q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (BLANK_BLACK && !de_next) begin
      q <= '0;
    end else begin
      q <= dim(c, 8'(lvl), SLW);
    end
  end

endmodule

// File: rtl/video_mixer_gen2.sv
// video_mixer_gen2: expands CW-bit core RGB to 8-bit VGA, applies scanline
// dimming and blank forcing, and registers HS/VS/DE with the same latency.
//   clk_sys, reset             - master clock, synchronous active-high reset
//   ce_pix / ce_pix_out        - pixel enable in / of the selected path
//   scandoubler, hq2x          - doubled-path select and filter (SD build only)
//   sl_level, sl_phase         - scanline strength and dimmed-line parity
//   mono                       - 1: all outputs take the green component
//   R, G, B                    - CW-bit colour input
//   HSync, VSync, HBlank, VBlank - positive syncs and blanks
//   VGA_R/G/B, VGA_HS/VS/DE    - registered outputs
// Build option: define VIDEO_MIXER_SD_EN to instantiate the scandoubler.
import video_mixer_pkg::*;

module video_mixer_gen2 #(
  parameter int unsigned LINE_LENGTH = 768,
  parameter int unsigned CW          = 8,
  parameter int unsigned SLW         = 2,
  parameter bit          BLANK_BLACK = 1'b1
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ce_pix,
  output logic           ce_pix_out,
  input  logic           scandoubler,
  input  logic           hq2x,
  input  logic [SLW-1:0] sl_level,
  input  logic           sl_phase,
  input  logic           mono,
  input  logic [CW-1:0]  R,
  input  logic [CW-1:0]  G,
  input  logic [CW-1:0]  B,
  input  logic           HSync,
  input  logic           VSync,
  input  logic           HBlank,
  input  logic           VBlank,
  output logic [7:0]     VGA_R,
  output logic [7:0]     VGA_G,
  output logic [7:0]     VGA_B,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_DE
);

  // S0: expansion register
  logic [7:0] r0, g0, b0;
  sync_t      s0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r0 <= '0;
      g0 <= '0;
      b0 <= '0;
      s0 <= '0;
    end else begin
      r0 <= expand8(8'(R), CW);
      g0 <= expand8(8'(G), CW);
      b0 <= expand8(8'(B), CW);
      s0 <= '{hs: HSync, vs: VSync, hb: HBlank, vb: VBlank};
    end
  end

  // S1: path select (combinational)
  logic [7:0] rp, gp, bp;
  sync_t      sp;

`ifdef VIDEO_MIXER_SD_EN
  logic       sd_ce;
  logic [7:0] sd_r, sd_g, sd_b;
  sync_t      sd_s;

  scandoubler #(
    .LENGTH     (LINE_LENGTH),
    .HALF_DEPTH (0)
  ) u_sd (
    .clk_vid    (clk_sys),
    .hq2x       (hq2x),
    .ce_pix     (ce_pix),
    .hs_in      (s0.hs),
    .vs_in      (s0.vs),
    .hb_in      (s0.hb),
    .vb_in      (s0.vb),
    .r_in       (r0),
    .g_in       (g0),
    .b_in       (b0),
    .ce_pix_out (sd_ce),
    .hs_out     (sd_s.hs),
    .vs_out     (sd_s.vs),
    .hb_out     (sd_s.hb),
    .vb_out     (sd_s.vb),
    .r_out      (sd_r),
    .g_out      (sd_g),
    .b_out      (sd_b)
  );

  always_comb begin
    ce_pix_out = scandoubler ? sd_ce : ce_pix;
    rp = scandoubler ? sd_r : r0;
    gp = scandoubler ? sd_g : g0;
    bp = scandoubler ? sd_b : b0;
    sp = scandoubler ? sd_s : s0;
  end
`else
  logic unused_sd;
  assign unused_sd  = ^{scandoubler, hq2x, (LINE_LENGTH != 0)};
  assign ce_pix_out = ce_pix;
  assign rp = r0;
  assign gp = g0;
  assign bp = b0;
  assign sp = s0;
`endif

  logic [7:0] r1, g1, b1;

  always_comb begin
    r1 = mono ? gp : rp;
    g1 = gp;
    b1 = mono ? gp : bp;
  end

  // Edge detection, line parity and DE, evaluated on the selected path
  logic           hs_d, vs_d, hb_d, parity;
  logic           hs_fall, vs_fall, hde_rise, hde_fall, de_next;
  logic [SLW-1:0] lvl;

  always_comb begin
    hs_fall  = !sp.hs && hs_d;
    vs_fall  = !sp.vs && vs_d;
    hde_rise = !sp.hb && hb_d;
    hde_fall = sp.hb && !hb_d;
    de_next  = VGA_DE;
    if (hde_rise) begin
      de_next = !sp.vb;
    end else if (hde_fall) begin
      de_next = 1'b0;
    end
    lvl = (parity ^ sl_phase) ? sl_level : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_d   <= 1'b0;
      vs_d   <= 1'b0;
      hb_d   <= 1'b0;
      parity <= 1'b0;
      VGA_HS <= 1'b0;
      VGA_VS <= 1'b0;
      VGA_DE <= 1'b0;
    end else begin
      hs_d   <= sp.hs;
      vs_d   <= sp.vs;
      hb_d   <= sp.hb;
      // VS clear takes priority over an HS toggle in the same cycle
      if (vs_fall) begin
        parity <= 1'b0;
      end else if (hs_fall) begin
        parity <= ~parity;
      end
      VGA_HS <= sp.hs;
      VGA_VS <= sp.vs;
      VGA_DE <= de_next;
    end
  end

  // S2: dim/blank output registers
  video_mixer_dim #(.SLW(SLW), .BLANK_BLACK(BLANK_BLACK)) u_dim_r (
    .clk(clk_sys), .reset(reset), .c(r1), .lvl(lvl), .de_next(de_next), .q(VGA_R)
  );
  video_mixer_dim #(.SLW(SLW), .BLANK_BLACK(BLANK_BLACK)) u_dim_g (
    .clk(clk_sys), .reset(reset), .c(g1), .lvl(lvl), .de_next(de_next), .q(VGA_G)
  );
  video_mixer_dim #(.SLW(SLW), .BLANK_BLACK(BLANK_BLACK)) u_dim_b (
    .clk(clk_sys), .reset(reset), .c(b1), .lvl(lvl), .de_next(de_next), .q(VGA_B)
  );

endmodule

// File: tb/tb_video_mixer_gen2.sv
// tb_video_mixer_gen2: directed-vector bench for video_mixer_gen2 (default
// build, VIDEO_MIXER_SD_EN undefined). Three instances share stimulus: CW=8
// (main), CW=3 and CW=1 (expansion checks).
import video_mixer_pkg::*;

module tb_video_mixer_gen2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic       scandoubler = 1'b0;
  logic       hq2x = 1'b0;
  logic [1:0] sl_level = 2'd2;
  logic       sl_phase = 1'b0;
  logic       mono = 1'b0;
  logic       hs = 1'b0, vs = 1'b0, hb = 1'b1, vb = 1'b1;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;

  logic       ce_out;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de;

  logic [7:0] r3, g3, b3, r1, g1, b1;
  logic       unused3_ce, unused3_hs, unused3_vs, unused3_de;
  logic       unused1_ce, unused1_hs, unused1_vs, unused1_de;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_mixer_gen2 #(.LINE_LENGTH(768), .CW(8), .SLW(2), .BLANK_BLACK(1'b1)) dut (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .ce_pix_out(ce_out),
    .scandoubler(scandoubler), .hq2x(hq2x), .sl_level(sl_level), .sl_phase(sl_phase),
    .mono(mono), .R(r_in), .G(g_in), .B(b_in),
    .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_DE(vga_de)
  );

  video_mixer_gen2 #(.LINE_LENGTH(768), .CW(3), .SLW(2), .BLANK_BLACK(1'b1)) dut3 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .ce_pix_out(unused3_ce),
    .scandoubler(scandoubler), .hq2x(hq2x), .sl_level(sl_level), .sl_phase(sl_phase),
    .mono(mono), .R(r_in[2:0]), .G(g_in[2:0]), .B(b_in[2:0]),
    .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
    .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
    .VGA_HS(unused3_hs), .VGA_VS(unused3_vs), .VGA_DE(unused3_de)
  );

  video_mixer_gen2 #(.LINE_LENGTH(768), .CW(1), .SLW(2), .BLANK_BLACK(1'b1)) dut1 (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .ce_pix_out(unused1_ce),
    .scandoubler(scandoubler), .hq2x(hq2x), .sl_level(sl_level), .sl_phase(sl_phase),
    .mono(mono), .R(r_in[0:0]), .G(g_in[0:0]), .B(b_in[0:0]),
    .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(unused1_hs), .VGA_VS(unused1_vs), .VGA_DE(unused1_de)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs/samples sit 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // HS pulse; on return the output shows the first pixel of the new line.
  task automatic hs_pulse();
    hs = 1'b1;
    tick(1);
    hs = 1'b0;
    tick(3);
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] exp);
    check_eq({tag, "_r"}, vga_r, exp);
    check_eq({tag, "_g"}, vga_g, exp);
    check_eq({tag, "_b"}, vga_b, exp);
  endtask

  initial begin
    // Reset state
    tick(2);
    check_rgb("reset", 8'h00);
    check_eq("reset_hs", vga_hs, 0);
    check_eq("reset_vs", vga_vs, 0);
    check_eq("reset_de", vga_de, 0);

    // Release, active line begins (parity 0, undimmed with sl_phase=0)
    reset = 1'b0;
    vb = 1'b0;
    tick(2);
    hb = 1'b0;
    r_in = 8'hA5; g_in = 8'hFF; b_in = 8'h12;
    tick(1);
    check_eq("lat1_de", vga_de, 0);
    check_eq("lat1_r", vga_r, 8'h00);
    tick(LAT_DIRECT - 1);
    check_eq("lat2_de", vga_de, 1);
    check_eq("cw8_r", vga_r, 8'hA5);
    check_eq("cw8_b", vga_b, 8'h12);
    check_eq("cw3_r", r3, 8'hB6);
    check_eq("cw3_g", g3, 8'hFF);
    check_eq("cw3_b", b3, 8'h49);
    check_eq("cw1_r", r1, 8'hFF);
    check_eq("cw1_g", g1, 8'hFF);
    check_eq("cw1_b", b1, 8'h00);

    // Scanline dimming
    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    tick(2);
    check_rgb("line0", 8'hFF);
    hs = 1'b1;
    tick(1);
    hs = 1'b0;
    tick(1);
    check_eq("hs_out", vga_hs, 1);
    tick(2);
    check_eq("hs_low", vga_hs, 0);
    check_rgb("line1_lvl2", 8'h7F);
    sl_level = 2'd3;
    tick(1);
    check_rgb("line1_lvl3", 8'h3F);
    sl_level = 2'd2;
    sl_phase = 1'b1;
    tick(1);
    check_rgb("line1_phase1", 8'hFF);
    sl_phase = 1'b0;
    tick(1);
    check_rgb("line1_phase0", 8'h7F);
    hs_pulse();
    check_rgb("line2", 8'hFF);

    // Mono
    r_in = 8'h10; g_in = 8'h80; b_in = 8'h00;
    mono = 1'b1;
    tick(2);
    check_rgb("mono", 8'h80);
    mono = 1'b0;
    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    tick(2);

    // HS and VS fall together from parity 0: cleared, not toggled
    hs = 1'b1; vs = 1'b1;
    tick(1);
    hs = 1'b0; vs = 1'b0;
    tick(1);
    check_eq("vs_out", vga_vs, 1);
    tick(2);
    check_rgb("hsvs_same", 8'hFF);
    hs_pulse();
    check_rgb("after_hsvs", 8'h7F);
    vs = 1'b1;
    tick(1);
    vs = 1'b0;
    tick(3);
    check_rgb("after_vs", 8'hFF);
    hs_pulse();
    check_rgb("vs_next_line", 8'h7F);

    // DE generation and blank forcing
    sl_level = 2'd0;
    hb = 1'b1;
    tick(2);
    check_eq("hb_rise_de", vga_de, 0);
    check_eq("hb_rise_r", vga_r, 8'h00);
    vb = 1'b1; hb = 1'b0;
    tick(2);
    check_eq("vblank_de", vga_de, 0);
    check_eq("vblank_r", vga_r, 8'h00);
    hb = 1'b1;
    tick(1);
    vb = 1'b0; hb = 1'b0;
    tick(2);
    check_eq("active_de", vga_de, 1);
    check_eq("active_r", vga_r, 8'hFF);

    // Reset mid-line (parity is 1 here)
    sl_level = 2'd2;
    tick(1);
    check_eq("pre_reset_r", vga_r, 8'h7F);
    reset = 1'b1;
    hb = 1'b1;
    tick(1);
    check_rgb("midreset", 8'h00);
    check_eq("midreset_de", vga_de, 0);
    reset = 1'b0;
    tick(2);
    hb = 1'b0;
    tick(1);
    check_eq("resume1_r", vga_r, 8'h00);
    tick(1);
    check_eq("resume2_de", vga_de, 1);
    check_eq("resume2_r", vga_r, 8'hFF);

    // Direct build: ce_pix_out follows ce_pix
    ce_pix = 1'b1;
    #1;
    check_eq("ce_hi", ce_out, 1);
    ce_pix = 1'b0;
    #1;
    check_eq("ce_lo", ce_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
